// File: rtl/imem_loader.sv
// ============================================================================
// Module   : imem_loader
// Brief    : Boot-time loader that assembles a little-endian byte stream into
//            32-bit words, writes them to instruction memory and then releases
//            the core from reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_valid,
  input  logic [7:0]            rx_data,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst_n,
  output logic                  start,
  output logic                  busy,
  output logic                  error
);

  localparam int          CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] CAPACITY = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_HDR0 = 3'd0,
    S_HDR1 = 3'd1,
    S_DATA = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [15:0]           n_q, n_d;
  logic [ADDR_WIDTH:0]   idx_q, idx_d;
  logic [1:0]            lane_q, lane_d;
  logic [23:0]           word_q, word_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rx_ready_q, rx_ready_d;
  logic                  imem_we_q, imem_we_d;
  logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
  logic [31:0]           imem_wdata_q, imem_wdata_d;
  logic                  core_rst_n_q, core_rst_n_d;
  logic                  start_q, start_d;
  logic                  busy_q, busy_d;
  logic                  error_q, error_d;

  logic                  accept;
  logic [15:0]           n_full;
  logic [CNT_W-1:0]      cnt_inc;
  logic                  timed_out;
  logic                  last_word;

  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    idx_d        = idx_q;
    lane_d       = lane_q;
    word_d       = word_q;
    cnt_d        = cnt_q;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr_q;
    imem_wdata_d = imem_wdata_q;

    accept    = rx_valid & rx_ready_q;
    n_full    = {rx_data, n_q[7:0]};
    cnt_inc   = cnt_q + CNT_W'(1);
    timed_out = (cnt_inc == CNT_W'(TIMEOUT_CYCLES));
    last_word = (({{(31 - ADDR_WIDTH){1'b0}}, idx_q} + 32'd1) == {16'd0, n_q});

    case (state_q)
      S_HDR0: begin
        cnt_d = '0;
        if (accept) begin
          n_d[7:0] = rx_data;
          state_d  = S_HDR1;
        end
      end
      S_HDR1: begin
        if (accept) begin
          n_d[15:8] = rx_data;
          cnt_d     = '0;
          idx_d     = '0;
          lane_d    = 2'd0;
          if (n_full == 16'd0) begin
            state_d = S_DONE;
          end else if ({16'd0, n_full} > CAPACITY) begin
            state_d = S_ERR;
          end else begin
            state_d = S_DATA;
          end
        end else begin
          cnt_d = cnt_inc;
          if (timed_out) state_d = S_ERR;
        end
      end
      S_DATA: begin
        if (accept) begin
          cnt_d  = '0;
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = rx_data;
            2'd1: word_d[15:8]  = rx_data;
            2'd2: word_d[23:16] = rx_data;
            default: begin
              imem_we_d    = 1'b1;
              imem_addr_d  = idx_q[ADDR_WIDTH-1:0];
              imem_wdata_d = {rx_data, word_q};
              idx_d        = idx_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
              if (last_word) state_d = S_DONE;
            end
          endcase
        end else begin
          cnt_d = cnt_inc;
          // Partial word is simply abandoned; nothing is written on timeout.
          if (timed_out) state_d = S_ERR;
        end
      end
      S_DONE, S_ERR: begin
        if (restart) begin
          state_d = S_HDR0;
          idx_d   = '0;
          lane_d  = 2'd0;
          cnt_d   = '0;
        end
      end
      default: state_d = S_HDR0;
    endcase

    // Status outputs follow the next state so they change on entry.
    rx_ready_d   = (state_d == S_HDR0) || (state_d == S_HDR1) || (state_d == S_DATA);
    busy_d       = (state_d == S_HDR1) || (state_d == S_DATA);
    error_d      = (state_d == S_ERR);
    start_d      = (state_q == S_DONE) && (state_d == S_DONE);
    core_rst_n_d = start_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_HDR0;
      n_q          <= '0;
      idx_q        <= '0;
      lane_q       <= 2'd0;
      word_q       <= '0;
      cnt_q        <= '0;
      rx_ready_q   <= 1'b0;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_rst_n_q <= 1'b0;
      start_q      <= 1'b0;
      busy_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      idx_q        <= idx_d;
      lane_q       <= lane_d;
      word_q       <= word_d;
      cnt_q        <= cnt_d;
      rx_ready_q   <= rx_ready_d;
      imem_we_q    <= imem_we_d;
      imem_addr_q  <= imem_addr_d;
      imem_wdata_q <= imem_wdata_d;
      core_rst_n_q <= core_rst_n_d;
      start_q      <= start_d;
      busy_q       <= busy_d;
      error_q      <= error_d;
    end
  end

  assign rx_ready   = rx_ready_q;
  assign imem_we    = imem_we_q;
  assign imem_addr  = imem_addr_q;
  assign imem_wdata = imem_wdata_q;
  assign core_rst_n = core_rst_n_q;
  assign start      = start_q;
  assign busy       = busy_q;
  assign error      = error_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module   : tb_imem_loader
// Brief    : Self-checking bench for imem_loader (ADDR_WIDTH=4, TIMEOUT=8).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;

  localparam int AW = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_ready;
  logic          restart = 1'b0;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst_n;
  logic          start;
  logic          busy;
  logic          error;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  int          got_addr[$];
  logic [31:0] got_data[$];
  int          exp_addr[$];
  logic [31:0] exp_data[$];

  imem_loader #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .restart(restart), .imem_we(imem_we),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
    .start(start), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Write monitor: imem_we is a one-cycle level, so each pulse is seen once.
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      got_addr.push_back(int'(imem_addr));
      got_data.push_back(imem_wdata);
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    ok = 1'b0;
    if (gap > 0) begin
      rx_valid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    rx_valid = 1'b1;
    rx_data  = b;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (rx_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_byte_timeout: rx_ready=%b required 1", rx_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  // Model: an image of N words produces writes addr i = word i, in order.
  task automatic build_expect(input logic [31:0] words[$]);
    exp_addr.delete();
    exp_data.delete();
    foreach (words[i]) begin
      exp_addr.push_back(i);
      exp_data.push_back(words[i]);
    end
  endtask

  task automatic send_image(input logic [31:0] words[$], input int max_gap);
    int n;
    logic [31:0] w;
    n = words.size();
    send_byte(n[7:0], (max_gap > 0) ? $urandom_range(max_gap) : 0);
    send_byte(n[15:8], (max_gap > 0) ? $urandom_range(max_gap) : 0);
    foreach (words[i]) begin
      w = words[i];
      for (int j = 0; j < 4; j++)
        send_byte(w[8*j +: 8], (max_gap > 0) ? $urandom_range(max_gap) : 0);
    end
    rx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({rx_ready, imem_we, core_rst_n, start, busy, error} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 000000",
               {rx_ready, imem_we, core_rst_n, start, busy, error});
    end
    checks++;
    if (imem_addr !== '0 || imem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_bus: addr=%h data=%h required 0", imem_addr, imem_wdata);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rx_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready: rx_ready=%b required 1", rx_ready);
    end
  endtask

  task automatic test_nominal();
    logic [31:0] words[$];
    int c0;
    words = '{32'h00500013, 32'h00A00093};
    build_expect(words);
    got_addr.delete();
    got_data.delete();
    c0 = cyc;
    send_byte(8'h02, 0);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL nominal_busy: busy=%b required 1", busy);
    end
    send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
    send_byte(8'h93, 0); send_byte(8'h00, 0); send_byte(8'hA0, 0); send_byte(8'h00, 0);
    rx_valid = 1'b0;
    checks++;
    if (cyc - c0 !== 10) begin
      failures++;
      $display("FAIL nominal_throughput: cycles=%0d required 10", cyc - c0);
    end
    checks++;
    if ({imem_we, start, core_rst_n, rx_ready} !== 4'b1000 || imem_addr !== 4'd1 ||
        imem_wdata !== 32'h00A00093) begin
      failures++;
      $display("FAIL nominal_last_write: we/start/crst/rdy=%b addr=%h data=%h required 1000 1 00a00093",
               {imem_we, start, core_rst_n, rx_ready}, imem_addr, imem_wdata);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({imem_we, start, core_rst_n, rx_ready, busy} !== 5'b01100) begin
      failures++;
      $display("FAIL nominal_release: we/start/crst/rdy/busy=%b required 01100",
               {imem_we, start, core_rst_n, rx_ready, busy});
    end
    checks++;
    if (got_addr.size() !== 2 || got_addr !== exp_addr || got_data !== exp_data) begin
      failures++;
      $display("FAIL nominal_writes: got %0d writes required 2 matching", got_addr.size());
    end
    do_restart();
    checks++;
    if ({rx_ready, start, core_rst_n, error} !== 4'b1000) begin
      failures++;
      $display("FAIL restart_done: rdy/start/crst/err=%b required 1000",
               {rx_ready, start, core_rst_n, error});
    end
  endtask

  task automatic test_gapped();
    logic [31:0] words[$];
    words = '{32'h00500013, 32'h00A00093};
    build_expect(words);
    got_addr.delete();
    got_data.delete();
    send_image(words, 5);
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    repeat (10) @(posedge clk);
    #1;
    checks++;
    if ({rx_ready, start, core_rst_n, busy} !== 4'b0110) begin
      failures++;
      $display("FAIL gapped_hold: rdy/start/crst/busy=%b required 0110",
               {rx_ready, start, core_rst_n, busy});
    end
    rx_valid = 1'b0;
    checks++;
    if (got_addr !== exp_addr || got_data !== exp_data) begin
      failures++;
      $display("FAIL gapped_writes: got %0d writes required %0d matching",
               got_addr.size(), exp_addr.size());
    end
    do_restart();
  endtask

  task automatic test_empty();
    got_addr.delete();
    got_data.delete();
    send_byte(8'h00, 0);
    send_byte(8'h00, 0);
    rx_valid = 1'b0;
    checks++;
    if ({start, core_rst_n, rx_ready} !== 3'b000) begin
      failures++;
      $display("FAIL empty_early: start/crst/rdy=%b required 000", {start, core_rst_n, rx_ready});
    end
    @(posedge clk);
    #1;
    checks++;
    if ({start, core_rst_n} !== 2'b11 || got_addr.size() !== 0) begin
      failures++;
      $display("FAIL empty_release: start/crst=%b writes=%0d required 11 0",
               {start, core_rst_n}, got_addr.size());
    end
    do_restart();
  endtask

  task automatic test_oversize();
    got_addr.delete();
    got_data.delete();
    send_byte(8'h11, 0);
    send_byte(8'h00, 0);
    rx_data = 8'hFF;
    checks++;
    if ({error, rx_ready, busy} !== 3'b100) begin
      failures++;
      $display("FAIL oversize_err: err/rdy/busy=%b required 100", {error, rx_ready, busy});
    end
    repeat (6) @(posedge clk);
    #1;
    rx_valid = 1'b0;
    checks++;
    if (core_rst_n !== 1'b0 || start !== 1'b0 || got_addr.size() !== 0) begin
      failures++;
      $display("FAIL oversize_hold: crst=%b start=%b writes=%0d required 0 0 0",
               core_rst_n, start, got_addr.size());
    end
    do_restart();
    checks++;
    if ({rx_ready, error} !== 2'b10) begin
      failures++;
      $display("FAIL oversize_restart: rdy/err=%b required 10", {rx_ready, error});
    end
  endtask

  task automatic test_timeout();
    got_addr.delete();
    got_data.delete();
    send_byte(8'h01, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0);
    rx_valid = 1'b0;
    repeat (TO - 1) @(posedge clk);
    #1;
    checks++;
    if (error !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL timeout_early: err=%b busy=%b required 0 1", error, busy);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({error, rx_ready, busy} !== 3'b100 || got_addr.size() !== 0) begin
      failures++;
      $display("FAIL timeout_err: err/rdy/busy=%b writes=%0d required 100 0",
               {error, rx_ready, busy}, got_addr.size());
    end
    do_restart();
  endtask

  task automatic test_reset_mid();
    logic [31:0] words[$];
    send_byte(8'h02, 0); send_byte(8'h00, 0);
    send_byte(8'h13, 0); send_byte(8'h00, 0); send_byte(8'h50, 0);
    rx_valid = 1'b0;
    #3 rst = 1'b0;
    #1;
    checks++;
    if ({rx_ready, imem_we, core_rst_n, start, busy, error} !== 6'b0 ||
        imem_addr !== '0 || imem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: flags=%b addr=%h data=%h required 0",
               {rx_ready, imem_we, core_rst_n, start, busy, error}, imem_addr, imem_wdata);
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    words = '{32'h00500013, 32'h00A00093};
    build_expect(words);
    got_addr.delete();
    got_data.delete();
    send_image(words, 0);
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (got_addr !== exp_addr || got_data !== exp_data || start !== 1'b1) begin
      failures++;
      $display("FAIL reload_writes: got %0d writes start=%b required 2 matching start=1",
               got_addr.size(), start);
    end
    do_restart();
  endtask

  task automatic test_random();
    logic [31:0] words[$];
    int n;
    for (int it = 0; it < 6; it++) begin
      words.delete();
      n = (it == 0) ? (1 << AW) : $urandom_range(1 << AW, 1);
      for (int i = 0; i < n; i++) words.push_back($urandom);
      build_expect(words);
      got_addr.delete();
      got_data.delete();
      send_image(words, 3);
      @(posedge clk);
      #1;
      checks++;
      if (got_addr !== exp_addr || got_data !== exp_data ||
          {start, core_rst_n, error} !== 3'b110) begin
        failures++;
        $display("FAIL random_image_%0d: got %0d writes start/crst/err=%b required %0d matching 110",
                 it, got_addr.size(), {start, core_rst_n, error}, n);
      end
      do_restart();
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_gapped();
    test_empty();
    test_oversize();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits directly upstream of the pipelined core's fetch stage. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit instruction words. It writes them sequentially into the instruction memory write port while holding the core in reset. When the image is complete it releases the core and raises `start`.

## Interface
Parameters:
- `ADDR_WIDTH`, default 10: instruction-memory word-address width; capacity is 2^ADDR_WIDTH words.
- `TIMEOUT_CYCLES`, default 1000000: maximum idle cycles between accepted bytes once a transfer has begun.

Ports:
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `rx_valid`  in  1  source presents a byte.
- `rx_data`  in  8  byte value.
- `rx_ready`  out  1  loader can accept a byte.
- `restart`  in  1  rearm the loader from DONE or ERR.
- `imem_we`  out  1  instruction-memory write strobe, one-cycle pulse.
- `imem_addr`  out  ADDR_WIDTH  word address.
- `imem_wdata`  out  32  instruction word.
- `core_rst_n`  out  1  active-low reset to the pipeline; 0 while loading.
- `start`  out  1  level; 1 once the image is loaded.
- `busy`  out  1  1 in HDR1 or DATA.
- `error`  out  1  1 in ERR.

## Operation
- Stream format: 2-byte word count N (little-endian, low byte first), then 4N bytes. Each word is sent low byte first, so the word is {b3,b2,b1,b0}.
- A byte is accepted on a rising edge with `rx_valid & rx_ready`. Nothing else consumes `rx_data`.
- State HDR0: `rx_ready`=1. On accept, latch N[7:0] and go to HDR1.
- State HDR1: on accept, latch N[15:8] and evaluate N:
  - N=0 → DONE, with no writes.
  - N > 2^ADDR_WIDTH → ERR.
  - otherwise → DATA, with word index 0 and byte lane 0.
- State DATA: each accept stores the byte in the current lane (0..3) and increments the lane.
  - On lane 3 accept, issue the write and increment the word index.
  - If the word index reaches N, go to DONE; otherwise stay in DATA.
- State DONE: `rx_ready`=0. `restart`=1 → HDR0, with the word index, lane and timeout counter cleared.
- State ERR: `rx_ready`=0, `error`=1. `restart`=1 → HDR0, with the word index, lane and timeout counter cleared.
- `restart` is ignored in HDR0, HDR1 and DATA.
- Timeout counter:
  - Active only in HDR1 and DATA.
  - Clears on every accepted byte.
  - Increments on every other cycle.
  - Reaching TIMEOUT_CYCLES → ERR.
  - HDR0 never times out.
- Partial words, whether caused by a timeout or a reset, are never written.
- Word index width is ADDR_WIDTH+1, so N = 2^ADDR_WIDTH is legal and fills memory exactly.

## Timing
- All outputs are registered.
- Reset values: `rx_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `core_rst_n`=0, `start`=0, `busy`=0, `error`=0. The state is HDR0.
- First edge after `rst` deasserts: `rx_ready`=1.
- `rx_ready` is updated from the next state, so it drops in the cycle the loader enters DONE or ERR. No byte is accepted after the last data byte or after a header error.
- Write latency:
  - `imem_we`=1 for exactly one cycle, in the cycle after the lane-3 byte is accepted.
  - `imem_addr` and `imem_wdata` are valid in that same cycle and hold until the next write.
- Release sequence:
  - `core_rst_n` and `start` rise together, one cycle after the final `imem_we` pulse, giving a 2-cycle gap after the last byte is accepted.
  - For N=0 they rise one cycle after DONE is entered.
- Restart: `core_rst_n`, `start` and `error` fall to 0 in the cycle HDR0 is re-entered, and `rx_ready`=1 in that same cycle.
- Asynchronous `rst` asserted mid-DATA:
  - All outputs go to their reset values immediately, without waiting for a clock edge.
  - The in-flight partial word is discarded.
- Back-to-back bytes, one per cycle, are sustained with no bubbles; throughput is 1 byte/cycle.

## Test plan
- Nominal load:
  - Stimulus: stream 02 00 | 13 00 50 00 | 93 00 A0 00, one byte per cycle.
  - Required: a write to addr 0 = 0x00500013, then a write to addr 1 = 0x00A00093. `core_rst_n`=1 and `start`=1 one cycle after the second `imem_we`. `rx_ready`=0 afterwards.
- Gapped source:
  - Stimulus: the same stream with `rx_valid` low for random 0–5 cycles between bytes; also hold `rx_valid` high while `rx_ready`=0 after completion.
  - Required: identical writes; no extra byte is consumed.
- Empty image:
  - Stimulus: stream 00 00.
  - Required: no `imem_we` pulse; `start`=1 and `core_rst_n`=1 two cycles after the second byte is accepted.
- Oversize image:
  - Stimulus: ADDR_WIDTH=4, stream 11 00 (N=17).
  - Required: `error`=1, `rx_ready`=0, no writes, `core_rst_n` stays 0. After a `restart` pulse, the loader is back in HDR0 with `rx_ready`=1 and `error`=0.
- Timeout:
  - Stimulus: TIMEOUT_CYCLES=8; send 01 00 13 00 50, then idle.
  - Required: `error`=1 after 8 idle cycles; no `imem_we` is issued.
- Reset mid-load:
  - Stimulus: assert `rst` low asynchronously between clock edges after 3 data bytes.
  - Required: all outputs read their reset values before the next clock edge. A full reload of the nominal stream after reset produces exactly the nominal writes.
